// File: rtl/rr_enc_arbiter_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface rr_enc_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_enc_arbiter.sv
// Eight-way round-robin arbiter with one-hot and encoded grant outputs,
// grant hold until release, and a hold-time watchdog.
module rr_enc_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic               clk,
    input logic               rst,
    rr_enc_arbiter_if.slave   bus
);

    localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state;
    logic [2:0]       ptr;
    logic [HoldW-1:0] hold_cnt;
    logic [7:0]       gnt;
    logic [2:0]       gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    logic             found;
    logic [2:0]       winner;
    logic [2:0]       cand;
    logic             rel;
    logic             wdog;

    // Rotating priority scan starting at ptr; the first requester found wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // A withdrawn request counts as a release, and any release beats the watchdog.
    assign rel  = bus.done || !bus.req[gnt_idx];
    assign wdog = (hold_cnt == HoldW'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                StIdle: begin
                    if (found) begin
                        gnt       <= 8'b1 << winner;
                        gnt_idx   <= winner;
                        gnt_valid <= 1'b1;
                        ptr       <= winner + 3'd1;
                        hold_cnt  <= '0;
                        state     <= StGrant;
                    end
                end
                StGrant: begin
                    if (rel || wdog) begin
                        gnt       <= 8'h00;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        timeout   <= !rel;
                        state     <= StIdle;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_idx   = gnt_idx;
    assign bus.gnt_valid = gnt_valid;
    assign bus.timeout   = timeout;

endmodule
